// File: rtl/reorder_buffer.sv
// Circular 3-wide reorder buffer: dispatch allocation, CDB completion, head window, retire, flush.
// Optional macro ROB_COMPLETE_FWD_EN forwards same-cycle CDB completions into rob_head_entry.
`ifndef SYS_XLEN
`define SYS_XLEN 32
`endif

package rob_pkg;
   typedef struct packed {
      logic [`SYS_XLEN-1:0] pc;
      logic [4:0]           dest_reg;
      logic                 completed;
      logic                 precise_state_need;
      logic [`SYS_XLEN-1:0] cs_retire_pc;
   } ROB_ENTRY_PACKET;
endpackage

module reorder_buffer
   import rob_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [2:0]                       dis_valid,
   input  ROB_ENTRY_PACKET [2:0]            dis_entry,
   output logic [1:0]                       rob_space,
   output logic [2:0][AW-1:0]               dis_rob_idx,
   input  logic [2:0]                       cdb_valid,
   input  logic [2:0][AW-1:0]               cdb_rob_idx,
   input  logic [2:0]                       cdb_mispredict,
   input  logic [2:0][`SYS_XLEN-1:0]        cdb_target_pc,
   output ROB_ENTRY_PACKET [2:0]            rob_head_entry,
   input  logic [2:0]                       Retire_EN,
   input  logic                             fch_rec_enable,
   output logic [AW:0]                      rob_count
);

   ROB_ENTRY_PACKET entries [DEPTH];
   ROB_ENTRY_PACKET alloc   [3];
   logic [AW-1:0]   head, tail;
   logic [AW:0]     count, free;
   logic [2:0]      acc;
   logic [1:0]      n_acc, n_ret;
   logic [AW-1:0]   win_idx [3];
   logic [AW-1:0]   cdb_off [3];

   assign rob_count = count;

   // Space comes from registered occupancy only; same-cycle retires are not credited.
   always_comb begin
      free      = (AW+1)'(DEPTH) - count;
      rob_space = (free >= (AW+1)'(3)) ? 2'd3 : free[1:0];
      acc[2]    = dis_valid[2] && (rob_space >= 2'd1);
      acc[1]    = dis_valid[1] && (rob_space >= 2'd2);
      acc[0]    = dis_valid[0] && (rob_space == 2'd3);
      n_acc     = 2'(acc[2]) + 2'(acc[1]) + 2'(acc[0]);
      n_ret     = 2'(Retire_EN[2]) + 2'(Retire_EN[1]) + 2'(Retire_EN[0]);
      for (int k = 0; k < 3; k++) begin
         dis_rob_idx[2-k]                = tail + AW'(k);
         alloc[k]                        = dis_entry[2-k];
         alloc[k].completed              = 1'b0;
         alloc[k].precise_state_need     = 1'b0;
         cdb_off[k]                      = cdb_rob_idx[k] - head;
      end
   end

   always_comb begin
      rob_head_entry = '0;
      for (int i = 0; i < 3; i++) begin
         win_idx[i] = head + AW'(i);
         if ((AW+1)'(i) < count) begin
            rob_head_entry[2-i] = entries[win_idx[i]];
`ifdef ROB_COMPLETE_FWD_EN
            for (int c = 0; c < 3; c++) begin
               if (cdb_valid[c] && (cdb_rob_idx[c] == win_idx[i])) begin
                  rob_head_entry[2-i].completed = 1'b1;
                  if (cdb_mispredict[c]) begin
                     rob_head_entry[2-i].precise_state_need = 1'b1;
                     rob_head_entry[2-i].cs_retire_pc       = cdb_target_pc[c];
                  end
               end
            end
`endif
         end
      end
   end

   // Accepted dispatch slots never overlap live entries, so retire-clear and allocation cannot collide.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      end else if (fch_rec_enable) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++)
            if (2'(i) < n_ret) entries[head + AW'(i)] <= '0;
         for (int c = 0; c < 3; c++) begin
            if (cdb_valid[c]) begin
               entries[cdb_rob_idx[c]].completed <= 1'b1;
               if (cdb_mispredict[c]) begin
                  entries[cdb_rob_idx[c]].precise_state_need <= 1'b1;
                  entries[cdb_rob_idx[c]].cs_retire_pc       <= cdb_target_pc[c];
               end
            end
         end
         for (int k = 0; k < 3; k++)
            if (acc[2-k]) entries[tail + AW'(k)] <= alloc[k];
         head  <= head + AW'(n_ret);
         tail  <= tail + AW'(n_acc);
         count <= count + (AW+1)'(n_acc) - (AW+1)'(n_ret);
      end
   end

   always @(posedge clock) begin
      if (!reset && !fch_rec_enable) begin
         assert ((dis_valid & ~acc) == 3'b000)
            else $warning("reorder_buffer: dispatch slots dropped, valid=%b space=%0d", dis_valid, rob_space);
         assert ((AW+1)'(n_ret) <= count)
            else $error("reorder_buffer: retire of %0d exceeds count %0d", n_ret, count);
         for (int c = 0; c < 3; c++)
            if (cdb_valid[c])
               assert ((AW+1)'(cdb_off[c]) < count)
                  else $error("reorder_buffer: completion to unallocated index %0d", cdb_rob_idx[c]);
      end
   end

endmodule
